burst_ram: RTL and testbench

Parametrised single-port synchronous RAM with a request/done handshake and burst transfers. One request moves 1..2^LEN_W beats from consecutive addresses, with configurable start-up wait states, per-byte write enables and write back-pressure. It is the successor to the plain CS/RW RAM. It replaces the shared tri-state data bus with separate read and write buses so it can sit directly behind the CPU bus unit or a DMA engine.

---
 rtl/burst_ram_pkg.sv | 18 +
 rtl/burst_ram_array.sv | 50 +++++
 rtl/burst_ram.sv | 138 +++++++++++++
 tb/tb_burst_ram.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_pkg.sv
// Shared constants and FSM state encoding for the burst RAM.
// Imported by the storage array and by the top-level controller.
package burst_ram_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam int   ZERO  = 0;

    // The wait counter covers start-up wait states in the range 0..15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } state_t;

endpackage

// File: rtl/burst_ram_array.sv
// Word storage for burst_ram: registered read, per-byte write enables,
// and an asynchronous clear of every word on res.
module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 wr_en_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [WIDTH/8-1:0]   wbe_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic [WIDTH-1:0]     rdata_o
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe_i[b] == TRUE) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read data holds its last value between read beats.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_ram.sv
// Single-port RAM with request/done handshake and 1..2^LEN_W beat bursts.
// Holds the request FSM, pointer/remaining/wait counters and output strobes.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = 2,
    parameter int WAIT   = 0
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [LEN_W-1:0]     len,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wbe,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rvalid,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state_o
);

    // Handshake: req is only looked at in IDLE and is dropped otherwise.
    // On a write burst a beat happens on each edge where wready && wvalid;
    // read beats never stall. rvalid/done pulse for one cycle after a beat.

    localparam logic [ADDR_W:0]          DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [WAIT_CNT_W-1:0]    WAIT_LAST = WAIT_CNT_W'(WAIT - 1);

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
    logic                    rvalid_q, rvalid_d;
    logic                    done_q, done_d;

    logic                    mem_we, mem_re, beat;
    logic [ADDR_W-1:0]       start_ptr, next_ptr;

    // Start addresses beyond DEPTH fold back once; addr < 2*DEPTH always holds.
    assign start_ptr = ({1'b0, addr} >= DEPTH_X) ? (addr - DEPTH_X[ADDR_W-1:0]) : addr;
    assign next_ptr  = (ptr_q == LAST_ADDR) ? '0 : (ptr_q + ADDR_W'(1));
    assign beat      = we_q ? wvalid : TRUE;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        wait_d   = wait_q;
        rvalid_d = FALSE;
        done_d   = FALSE;
        mem_we   = FALSE;
        mem_re   = FALSE;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    ptr_d   = start_ptr;
                    rem_d   = len;
                    wait_d  = WAIT_CNT_W'(ZERO);
                    state_d = (WAIT > ZERO) ? ST_WAIT : ST_XFER;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_XFER;
                end else begin
                    wait_d = wait_q + WAIT_CNT_W'(1);
                end
            end
            ST_XFER: begin
                if (beat) begin
                    mem_we   = we_q;
                    mem_re   = !we_q;
                    rvalid_d = !we_q;
                    ptr_d    = next_ptr;
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == '0) begin
                        done_d  = TRUE;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= ST_IDLE;
            we_q     <= FALSE;
            ptr_q    <= '0;
            rem_q    <= '0;
            wait_q   <= '0;
            rvalid_q <= FALSE;
            done_q   <= FALSE;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    burst_ram_array #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .res     (res),
        .wr_en_i (mem_we),
        .rd_en_i (mem_re),
        .addr_i  (ptr_q),
        .wbe_i   (wbe),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign wready      = (state_q == ST_XFER) && we_q;
    assign rvalid      = rvalid_q;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: a WAIT=0 instance for the main scenarios
// and a WAIT=3 instance for the start-up latency; a bench-side memory model feeds exp_q.
module tb_burst_ram;

    localparam int W  = 16;
    localparam int D  = 256;
    localparam int AW = 8;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          res;
    logic          req, req_w, we, wvalid;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [W-1:0]  wdata;
    logic [1:0]    wbe;

    logic          wready, rvalid, busy, done;
    logic [W-1:0]  rdata;
    logic [1:0]    dbg_state;
    logic          wready_w, rvalid_w, busy_w, done_w;
    logic [W-1:0]  rdata_w;
    logic [1:0]    dbg_state_w;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] model [D];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] wd [4];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    burst_ram #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .LEN_W(LW), .WAIT(0)) dut (
        .clk(clk), .res(res), .req(req), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .wbe(wbe), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .done(done),
        .dbg_state_o(dbg_state)
    );

    burst_ram #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .LEN_W(LW), .WAIT(3)) dut_w (
        .clk(clk), .res(res), .req(req_w), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .wbe(wbe), .wvalid(wvalid), .wready(wready_w),
        .rdata(rdata_w), .rvalid(rvalid_w), .busy(busy_w), .done(done_w),
        .dbg_state_o(dbg_state_w)
    );

    // ---------------- driver tasks ----------------
    task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                              input int exp_lat, input bit hold_req);
        int nl, beats, cyc, first;
        logic [W-1:0]  e;
        logic [AW-1:0] p;
        nl = int'(l) + 1;
        p  = a;
        for (int k = 0; k < nl; k++) begin
            exp_q.push_back(model[p]);
            p = p + 8'd1;
        end
        req = 1'b1; we = 1'b0; addr = a; len = l; wvalid = 1'b0;
        @(posedge clk); #1;
        if (hold_req) begin
            req = 1'b1; we = 1'b1; addr = 8'd60; len = 2'd3;
            wvalid = 1'b1; wdata = 16'hFFFF; wbe = 2'b11;
        end else begin
            req = 1'b0;
        end
        beats = 0; cyc = 0; first = -1;
        while (beats < nl && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (rvalid === 1'b1) begin
                if (first < 0) first = cyc;
                e = exp_q.pop_front();
                beats++;
                checks++;
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL read_data addr=%0d beat=%0d got=%h exp=%h", a, beats - 1, rdata, e);
                end
                checks++;
                if (done !== (beats == nl)) begin
                    errors++;
                    $display("FAIL read_done beat=%0d got=%b exp=%b", beats - 1, done, (beats == nl));
                end
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL read_done_idle cyc=%0d got=%b exp=0", cyc, done);
                end
            end
        end
        req = 1'b0; wvalid = 1'b0;
        checks++;
        if (beats != nl) begin
            errors++;
            $display("FAIL read_timeout addr=%0d got_beats=%0d exp=%0d", a, beats, nl);
            exp_q.delete();
        end
        checks++;
        if (first != exp_lat) begin
            errors++;
            $display("FAIL read_latency addr=%0d got=%0d exp=%0d", a, first, exp_lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_busy_end got=%b exp=0", busy);
        end
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                               input logic [1:0] m, input int stall_beat, input int stall_n);
        int nl, b, cyc, stalls;
        logic [AW-1:0] p;
        nl = int'(l) + 1;
        p  = a;
        req = 1'b1; we = 1'b1; addr = a; len = l; wbe = m; wvalid = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        b = 0; cyc = 0; stalls = 0;
        while (b < nl && cyc < 30) begin
            if (b == stall_beat && stalls < stall_n) begin
                wvalid = 1'b0;
                stalls++;
            end else begin
                wvalid = 1'b1;
                wdata  = wd[b];
            end
            checks++;
            if (wready !== 1'b1) begin
                errors++;
                $display("FAIL write_ready cyc=%0d got=%b exp=1", cyc, wready);
            end
            @(posedge clk); #1;
            cyc++;
            if (wvalid) begin
                for (int i = 0; i < 2; i++) begin
                    if (m[i]) model[p][i*8 +: 8] = wd[b][i*8 +: 8];
                end
                p = p + 8'd1;
                b++;
            end
            checks++;
            if (done !== (b == nl)) begin
                errors++;
                $display("FAIL write_done cyc=%0d got=%b exp=%b", cyc, done, (b == nl));
            end
        end
        wvalid = 1'b0;
        checks++;
        if (cyc != nl + stall_n) begin
            errors++;
            $display("FAIL write_cycles addr=%0d got=%0d exp=%0d", a, cyc, nl + stall_n);
        end
        checks++;
        if (busy !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL write_end busy=%b wready=%b exp=0/0", busy, wready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({rdata, rvalid, done, busy, wready, dbg_state} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h rv=%b done=%b busy=%b wr=%b st=%0d exp all 0",
                     rdata, rvalid, done, busy, wready, dbg_state);
        end
    endtask

    task automatic test_wait_states();
        int cyc, beats, first;
        req_w = 1'b1; we = 1'b0; addr = 8'd254; len = 2'd3;
        @(posedge clk); #1;
        req_w = 1'b0;
        cyc = 0; beats = 0; first = -1;
        checks++;
        if (busy_w !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy got=%b exp=1", busy_w);
        end
        while (beats < 4 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (rvalid_w === 1'b1) begin
                if (first < 0) first = cyc;
                beats++;
                checks++;
                if (rdata_w !== 16'h0000 || done_w !== (beats == 4)) begin
                    errors++;
                    $display("FAIL wait_beat beat=%0d rdata=%h done=%b exp 0000/%b",
                             beats - 1, rdata_w, done_w, (beats == 4));
                end
            end
        end
        checks++;
        if (first != 4 || beats != 4) begin
            errors++;
            $display("FAIL wait_latency got first=%0d beats=%0d exp 4/4", first, beats);
        end
        checks++;
        if (busy_w !== 1'b0) begin
            errors++;
            $display("FAIL wait_busy_end got=%b exp=0", busy_w);
        end
    endtask

    task automatic test_single_read();
        read_burst(8'd5, 2'd0, 1, 1'b0);
    endtask

    task automatic test_write_read_burst();
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        write_burst(8'd10, 2'd3, 2'b11, -1, 0);
        read_burst(8'd10, 2'd3, 1, 1'b0);
    endtask

    task automatic test_byte_enable();
        wd[0] = 16'h1234;
        write_burst(8'd20, 2'd0, 2'b11, -1, 0);
        wd[0] = 16'hABCD;
        write_burst(8'd20, 2'd0, 2'b01, -1, 0);
        read_burst(8'd20, 2'd0, 1, 1'b0);
        wd[0] = 16'h5A5A;
        write_burst(8'd21, 2'd0, 2'b10, -1, 0);
        read_burst(8'd21, 2'd0, 1, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) wd[i] = 16'(($urandom_range(0, 65535)));
        write_burst(8'd40, 2'd3, 2'b11, 2, 2);
        read_burst(8'd39, 2'd3, 1, 1'b0);
        read_burst(8'd43, 2'd0, 1, 1'b0);
    endtask

    task automatic test_wrap();
        wd[0] = 16'hFE00; wd[1] = 16'hFF01; wd[2] = 16'h0002; wd[3] = 16'h0103;
        write_burst(8'd254, 2'd3, 2'b11, -1, 0);
        read_burst(8'd254, 2'd3, 1, 1'b0);
        read_burst(8'd0, 2'd1, 1, 1'b0);
    endtask

    task automatic test_req_while_busy();
        read_burst(8'd10, 2'd3, 1, 1'b1);
        read_burst(8'd60, 2'd3, 1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        wd[0] = 16'hC0C0; wd[1] = 16'hC1C1; wd[2] = 16'hC2C2; wd[3] = 16'hC3C3;
        req = 1'b1; we = 1'b1; addr = 8'd30; len = 2'd3; wbe = 2'b11;
        @(posedge clk); #1;
        req = 1'b0; wvalid = 1'b1; wdata = wd[0];
        @(posedge clk); #1;
        wdata = wd[1];
        @(posedge clk); #1;
        wdata = wd[2];
        #2 res = 1'b1;
        #1;
        checks++;
        if ({rdata, rvalid, done, busy, wready} !== 20'd0) begin
            errors++;
            $display("FAIL abort_outputs rdata=%h rv=%b done=%b busy=%b wr=%b exp all 0",
                     rdata, rvalid, done, busy, wready);
        end
        @(negedge clk);
        res = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
        @(posedge clk); #1;
        read_burst(8'd30, 2'd3, 1, 1'b0);
        read_burst(8'd10, 2'd3, 1, 1'b0);
        read_burst(8'd20, 2'd1, 1, 1'b0);
        read_burst(8'd254, 2'd3, 1, 1'b0);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        res = 1'b1; req = 1'b0; req_w = 1'b0; we = 1'b0; addr = '0; len = '0;
        wdata = '0; wbe = '0; wvalid = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_wait_states();
        test_single_read();
        test_write_read_burst();
        test_byte_enable();
        test_stall();
        test_wrap();
        test_req_while_busy();
        test_reset_mid_burst();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
